// File: rtl/irq_request_latch_if.sv
// Bundle between the interrupt request latch and its consumer/encoder side.
// The overrun field exists only when IRQ_OVERRUN_EN is defined.
interface irq_request_latch_if #(
  parameter int unsigned N_IRQ = 8
);
  localparam int unsigned IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] irq_raw;
  logic             mask_wr;
  logic [N_IRQ-1:0] mask_wdata;
  logic             clr_valid;
  logic [IDXW-1:0]  clr_idx;
  logic [N_IRQ-1:0] req_vec;
  logic             irq_any;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
`ifdef IRQ_OVERRUN_EN
  logic [N_IRQ-1:0] overrun;
`endif

  // Consumer side: drives raw lines, mask writes and clears
  modport master (
    output irq_raw, mask_wr, mask_wdata, clr_valid, clr_idx,
    input  req_vec, irq_any, pending, mask
`ifdef IRQ_OVERRUN_EN
    , input overrun
`endif
  );

  // Latch side
  modport slave (
    input  irq_raw, mask_wr, mask_wdata, clr_valid, clr_idx,
    output req_vec, irq_any, pending, mask
`ifdef IRQ_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/irq_request_latch.sv
// Interrupt request latch: synchronises raw lines, detects rising edges,
// holds them in a sticky pending register and exposes pending & mask.
// Optional sticky overrun flags are built when IRQ_OVERRUN_EN is defined.
module irq_request_latch #(
  parameter int unsigned    N_IRQ       = 8,
  parameter int unsigned    SYNC_STAGES = 2,
  parameter logic [N_IRQ-1:0] RESET_MASK = '1
) (
  input logic               clk,
  input logic               rst,
  irq_request_latch_if.slave bus
);
  localparam int unsigned IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] sync_s;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr_hit;
  logic [N_IRQ-1:0] pending_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~prev_q;

  // Per-bit clear decode; indices beyond N_IRQ-1 never match
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      clr_hit[i] = bus.clr_valid && (bus.clr_idx == IDXW'(i));
    end
  end

  // Set wins over clear so a new event is never lost
  assign pending_d = rise | (pending_q & ~clr_hit);

  // Synchroniser chain and edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_raw};
      prev_q <= sync_s;
    end
  end

  // Sticky pending register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Software mask register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= RESET_MASK;
    end else if (bus.mask_wr) begin
      mask_q <= bus.mask_wdata;
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [N_IRQ-1:0] overrun_q;

  // Overrun: an edge arrived while the bit was still pending; set wins over clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= (rise & pending_q) | (overrun_q & ~clr_hit);
    end
  end

  assign bus.overrun = overrun_q;
`endif

  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;
  assign bus.req_vec = pending_q & mask_q;
  assign bus.irq_any = |(pending_q & mask_q);
endmodule
